// File: rtl/axis_sub_one_pkg.sv
// Shared definitions for the byte-wise add-one / sub-one stream stages and their checkers.
package axis_sub_one_pkg;

    localparam int unsigned LANE_WIDTH     = 8;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned KEEP_WIDTH     = DEF_DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned MAX_KEEP_WIDTH = 128;
    localparam int unsigned POP_WIDTH      = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    function automatic logic [LANE_WIDTH-1:0] dec_lane(input logic [LANE_WIDTH-1:0] lane);
        return lane - LANE_WIDTH'(1);
    endfunction

    // Number of set bits; callers zero-extend their tkeep to MAX_KEEP_WIDTH.
    function automatic logic [POP_WIDTH-1:0] popcount(input logic [MAX_KEEP_WIDTH-1:0] v);
        logic [POP_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_KEEP_WIDTH; i++) begin
            cnt = cnt + POP_WIDTH'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Registered full-throughput skid buffer: output register plus one skid entry, registered ready.
module axis_skid_buffer
    import axis_sub_one_pkg::*;
#(
    parameter int unsigned WIDTH = 36
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             in_xfer;
    logic             out_xfer;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        in_xfer     = s_valid & ready_q;
        out_xfer    = valid_q & m_ready;

        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    out_data_d = s_data;
                    state_d    = ONE;
                end
            end
            ONE: begin
                // A simultaneous in/out transfer bypasses the skid entry.
                if (in_xfer && out_xfer) begin
                    out_data_d = s_data;
                end else if (in_xfer) begin
                    skid_data_d = s_data;
                    state_d     = FULL;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    out_data_d = skid_data_q;
                    state_d    = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        valid_d = (state_d != EMPTY);
        ready_d = (state_d != FULL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            out_data_q  <= '0;
            skid_data_q <= '0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
            valid_q     <= valid_d;
            ready_q     <= ready_d;
        end
    end

    assign s_ready = ready_q;
    assign m_data  = out_data_q;
    assign m_valid = valid_q;

endmodule

// File: rtl/axis_sub_one.sv
// AXI4-Stream byte-wise decrement stage with delivered-beat and kept-byte counters.
module axis_sub_one
    import axis_sub_one_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [COUNT_WIDTH-1:0]    beat_count,
    output logic [COUNT_WIDTH-1:0]    byte_count
);

    localparam int unsigned KEEP_W    = DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned PAYLOAD_W = DATA_WIDTH + KEEP_W;

    logic [DATA_WIDTH-1:0]  dec_data;
    logic [PAYLOAD_W-1:0]   in_payload;
    logic [PAYLOAD_W-1:0]   out_payload;
    logic [COUNT_WIDTH-1:0] beat_q, beat_d;
    logic [COUNT_WIDTH-1:0] byte_q, byte_d;

    // Decrement before registering so the skid buffer carries finished data.
    always_comb begin
        dec_data = '0;
        for (int i = 0; i < int'(KEEP_W); i++) begin
            dec_data[i*LANE_WIDTH +: LANE_WIDTH] = dec_lane(s_axis_tdata[i*LANE_WIDTH +: LANE_WIDTH]);
        end
    end

    assign in_payload = {s_axis_tkeep, dec_data};

    axis_skid_buffer #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .s_data  (in_payload),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .m_data  (out_payload),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

    assign m_axis_tdata = out_payload[DATA_WIDTH-1:0];
    assign m_axis_tkeep = out_payload[PAYLOAD_W-1:DATA_WIDTH];

    always_comb begin
        beat_d = beat_q;
        byte_d = byte_q;
        if (m_axis_tvalid && m_axis_tready) begin
            beat_d = beat_q + COUNT_WIDTH'(1);
            byte_d = byte_q + COUNT_WIDTH'(popcount(MAX_KEEP_WIDTH'(m_axis_tkeep)));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            beat_q <= '0;
            byte_q <= '0;
        end else begin
            beat_q <= beat_d;
            byte_q <= byte_d;
        end
    end

    assign beat_count = beat_q;
    assign byte_count = byte_q;

endmodule

// File: tb/tb_axis_sub_one.sv
// Randomized bench for axis_sub_one against a queue-based reference model plus literal directed checks.
module tb_axis_sub_one;

    logic        clock;
    logic        reset;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] beat_count;
    logic [31:0] byte_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state: beats accepted but not yet delivered, oldest first.
    logic [35:0] exp_q[$];
    logic [31:0] beat_m   = '0;
    logic [31:0] byte_m   = '0;
    bit          started  = 0;
    bit          rst_seen = 0;
    bit          acc_flag = 0;
    int          acc_count = 0;

    axis_sub_one #(
        .DATA_WIDTH  (32),
        .COUNT_WIDTH (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .s_axis_tdata  (s_data),
        .s_axis_tkeep  (s_keep),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .m_axis_tdata  (m_data),
        .m_axis_tkeep  (m_keep),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .beat_count    (beat_count),
        .byte_count    (byte_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_dec(input logic [31:0] d);
        int unsigned r;
        int unsigned b;
        r = 0;
        for (int l = 0; l < 4; l++) begin
            b = (int'(d) >> (8 * l)) & 255;
            b = (b + 255) % 256;
            r = r | (b << (8 * l));
        end
        return 32'(r);
    endfunction

    // Model update on each rising edge from the pre-edge handshake values.
    initial begin
        logic [35:0] front;
        forever begin
            @(posedge clock);
            if (reset) begin
                exp_q.delete();
                beat_m   = '0;
                byte_m   = '0;
                rst_seen = 1;
                started  = 1;
                acc_flag = 0;
            end else begin
                rst_seen = 0;
                acc_flag = 0;
                if (started) begin
                    if (m_valid && m_ready && exp_q.size() > 0) begin
                        front  = exp_q.pop_front();
                        beat_m = beat_m + 32'd1;
                        byte_m = byte_m + 32'($countones(front[35:32]));
                    end
                    if (s_valid && s_ready) begin
                        exp_q.push_back({s_keep, model_dec(s_data)});
                        acc_flag  = 1;
                        acc_count = acc_count + 1;
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, outputs against the model.
    initial begin
        forever begin
            @(negedge clock);
            if (started) begin
                if (rst_seen) begin
                    chk("rst_ready", 64'(s_ready), 64'd0);
                    chk("rst_valid", 64'(m_valid), 64'd0);
                    chk("rst_data", 64'(m_data), 64'd0);
                    chk("rst_keep", 64'(m_keep), 64'd0);
                end else begin
                    chk("ready_vs_occupancy", 64'(s_ready), 64'(exp_q.size() < 2));
                    chk("valid_vs_occupancy", 64'(m_valid), 64'(exp_q.size() != 0));
                    if (exp_q.size() > 0) begin
                        chk("out_data", 64'(m_data), 64'(exp_q[0][31:0]));
                        chk("out_keep", 64'(m_keep), 64'(exp_q[0][35:32]));
                    end
                end
                chk("beat_count", 64'(beat_count), 64'(beat_m));
                chk("byte_count", 64'(byte_count), 64'(byte_m));
            end
        end
    end

    // Called at a falling edge with the DUT empty and ready.
    task automatic send_one(input logic [31:0] d, input logic [3:0] k, input logic [31:0] exp_d,
                            input logic [31:0] exp_beat, input logic [31:0] exp_byte);
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        @(negedge clock);
        chk("lit_data", 64'(m_data), 64'(exp_d));
        chk("lit_keep", 64'(m_keep), 64'(k));
        chk("lit_valid", 64'(m_valid), 64'd1);
        s_valid = 1'b0;
        @(negedge clock);
        chk("lit_beat", 64'(beat_count), 64'(exp_beat));
        chk("lit_byte", 64'(byte_count), 64'(exp_byte));
    endtask

    initial begin
        logic [31:0] b0;
        int          cyc;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_keep  = '0;
        m_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", 64'(s_ready), 64'd1);

        // Single beat, lane wrap, partial keep.
        send_one(32'h01020304, 4'hF, 32'h00010203, 32'd1, 32'd4);
        send_one(32'h00FF8001, 4'hF, 32'hFFFE7F00, 32'd2, 32'd8);
        send_one(32'h11111111, 4'h3, 32'h10101010, 32'd3, 32'd10);

        // Backpressure: A and B accepted, C held until release.
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 32'hA0A0A0A0; s_keep = 4'hF;
        @(negedge clock);
        chk("bp_ready_after_A", 64'(s_ready), 64'd1);
        s_data = 32'h00000000; s_keep = 4'h1;
        @(negedge clock);
        chk("bp_ready_after_B", 64'(s_ready), 64'd0);
        s_data = 32'h10203040; s_keep = 4'h7;
        @(negedge clock);
        chk("bp_C_held", 64'(s_ready), 64'd0);
        chk("bp_out_A", 64'(m_data), 64'h9F9F9F9F);
        m_ready = 1'b1;
        @(negedge clock);
        chk("bp_out_B", 64'(m_data), 64'hFFFFFFFF);
        chk("bp_out_B_keep", 64'(m_keep), 64'h1);
        @(negedge clock);
        chk("bp_out_C", 64'(m_data), 64'h0F1F2F3F);
        s_valid = 1'b0;
        @(negedge clock);
        chk("bp_drained", 64'(m_valid), 64'd0);
        chk("bp_beats", 64'(beat_count), 64'd6);

        // Streaming: 16 back-to-back beats.
        b0 = beat_count;
        m_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            s_valid = 1'b1;
            s_data  = $urandom;
            s_keep  = 4'hF;
            @(negedge clock);
            chk("stream_valid", 64'(m_valid), 64'd1);
        end
        s_valid = 1'b0;
        @(negedge clock);
        chk("stream_beats", 64'(beat_count), 64'(b0 + 32'd16));
        chk("stream_idle", 64'(m_valid), 64'd0);

        // Random backpressure over 1000 accepted beats.
        acc_count = 0;
        cyc = 0;
        while (acc_count < 1000 && cyc < 20000) begin
            m_ready = ($urandom_range(0, 99) < 60);
            if (!s_valid || acc_flag) begin
                s_valid = ($urandom_range(0, 99) < 75);
                s_data  = $urandom;
                s_keep  = 4'($urandom);
            end
            @(negedge clock);
            cyc++;
        end
        chk("random_done", 64'(acc_count >= 1000), 64'd1);
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (4) @(negedge clock);
        chk("random_drained", 64'(m_valid), 64'd0);

        // Reset while FULL.
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 32'h55555555; s_keep = 4'hF;
        @(negedge clock);
        s_data = 32'h66666666;
        @(negedge clock);
        chk("pre_reset_full", 64'(s_ready), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_valid", 64'(m_valid), 64'd0);
        chk("rst_mid_beat", 64'(beat_count), 64'd0);
        chk("rst_mid_byte", 64'(byte_count), 64'd0);
        chk("rst_mid_ready", 64'(s_ready), 64'd0);
        reset   = 1'b0;
        s_valid = 1'b0;
        @(negedge clock);
        chk("post_reset_ready", 64'(s_ready), 64'd1);
        send_one(32'h00000001, 4'hF, 32'hFFFFFF00, 32'd1, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
